interpolator_nx: RTL and testbench

INTERPOLATOR_NX -- requirements
Module: interpolator_nx

---
 rtl/interpolator_pkg.sv | 22 ++
 rtl/interpolator_coef_rom.sv | 23 ++
 rtl/interpolator_nx.sv | 173 +++++++++++++++++
 tb/tb_interpolator_nx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interpolator_pkg.sv
// Shared types and elaboration helpers for the interpolator_nx linear upsampler.
package interpolator_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DATA_W_MIN = 4;
    localparam int DATA_W_MAX = 16;
    localparam int RATIO_MIN  = 2;
    localparam int RATIO_MAX  = 256;
    localparam int COEF_W_MIN = 4;
    localparam int COEF_W_MAX = 16;

    // round(k * 2^coef_w / ratio), ties rounded up, in pure integer form
    function automatic int coef1(input int k, input int ratio, input int coef_w);
        return ((k << (coef_w + 1)) + ratio) / (2 * ratio);
    endfunction

endpackage

// File: rtl/interpolator_coef_rom.sv
// Constant phase-to-coefficient table: k -> {c0_k, c1_k}, with c0_k + c1_k = 2^COEF_W.
module interpolator_coef_rom
    import interpolator_pkg::*;
#(
    parameter int RATIO  = 10,
    parameter int COEF_W = 8,
    parameter int K_W    = $clog2(RATIO)
) (
    input  logic [K_W-1:0]  k,
    output logic [COEF_W:0] c0,
    output logic [COEF_W:0] c1
);

    logic [COEF_W:0] c1_tab [RATIO];

    for (genvar i = 0; i < RATIO; i++) begin : g_tab
        assign c1_tab[i] = (COEF_W + 1)'(coef1(i, RATIO, COEF_W));
    end

    assign c1 = c1_tab[k];
    assign c0 = (COEF_W + 1)'(1 << COEF_W) - c1;

endmodule

// File: rtl/interpolator_nx.sv
// Linear interpolating upsampler: RATIO outputs between consecutive input samples.
// Build option: define INTERPOLATOR_SIGNED_EN for two's-complement samples and arithmetic.
module interpolator_nx
    import interpolator_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RATIO  = 10,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(RATIO)-1:0] out_phase,
    output logic                     out_last,
    output state_t                   fsm_state
);

    localparam int K_W = $clog2(RATIO);
    localparam int PW  = DATA_W + COEF_W + 3;
    localparam logic [K_W-1:0]       K_LAST = K_W'(RATIO - 1);
    localparam logic signed [PW-1:0] HALF   = PW'(1 << (COEF_W - 1));

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        RATIO  < RATIO_MIN  || RATIO  > RATIO_MAX  ||
        COEF_W < COEF_W_MIN || COEF_W > COEF_W_MAX) begin : g_bad_param
        $error("interpolator_nx: parameter out of range");
    end

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both high;
    // a held output (out_valid && !out_ready) freezes the whole block.
    state_t            state, state_n;
    logic [K_W-1:0]    k, k_n;
    logic [DATA_W-1:0] x0, x1;
    logic              live, stall, accept, issue;

    assign stall     = out_valid && !out_ready;
    assign fsm_state = state;

    always_comb begin
        state_n  = state;
        k_n      = k;
        in_ready = 1'b0;
        issue    = 1'b0;
        case (state)
            PRIME: begin
                in_ready = live && !stall;
                if (in_valid && in_ready) state_n = IDLE;
            end
            IDLE: begin
                in_ready = live && !stall;
                if (in_valid && in_ready) begin
                    state_n = RUN;
                    k_n     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (k == K_LAST) begin
                        // A new sample on the final phase restarts the interval seamlessly
                        in_ready = 1'b1;
                        k_n      = '0;
                        state_n  = in_valid ? RUN : IDLE;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            default: state_n = PRIME;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PRIME;
            k     <= '0;
            live  <= 1'b0;
            x0    <= '0;
            x1    <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            live  <= 1'b1;
            if (accept) begin
                x0 <= x1;
                x1 <= in_data;
            end
        end
    end

    // Issue stage captures the phase together with its sample pair
    logic              iv;
    logic [K_W-1:0]    ik;
    logic [DATA_W-1:0] ix0, ix1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iv  <= 1'b0;
            ik  <= '0;
            ix0 <= '0;
            ix1 <= '0;
        end else if (!stall) begin
            iv  <= issue;
            ik  <= k;
            ix0 <= x0;
            ix1 <= x1;
        end
    end

    logic [COEF_W:0]       c0, c1;
    logic signed [PW-1:0]  x0e, x1e, c0e, c1e;

    interpolator_coef_rom #(
        .RATIO  (RATIO),
        .COEF_W (COEF_W),
        .K_W    (K_W)
    ) u_coef_rom (
        .k  (ik),
        .c0 (c0),
        .c1 (c1)
    );

`ifdef INTERPOLATOR_SIGNED_EN
    assign x0e = {{(PW - DATA_W){ix0[DATA_W-1]}}, ix0};
    assign x1e = {{(PW - DATA_W){ix1[DATA_W-1]}}, ix1};
`else
    assign x0e = {{(PW - DATA_W){1'b0}}, ix0};
    assign x1e = {{(PW - DATA_W){1'b0}}, ix1};
`endif
    assign c0e = {{(PW - COEF_W - 1){1'b0}}, c0};
    assign c1e = {{(PW - COEF_W - 1){1'b0}}, c1};

    logic                 pv;
    logic [K_W-1:0]       pk;
    logic signed [PW-1:0] p0, p1, sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= 1'b0;
            pk <= '0;
            p0 <= '0;
            p1 <= '0;
        end else if (!stall) begin
            pv <= iv;
            pk <= ik;
            p0 <= x0e * c0e;
            p1 <= x1e * c1e;
        end
    end

    assign sum = p0 + p1 + HALF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_phase <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= pv;
            out_data  <= DATA_W'(sum >>> COEF_W);
            out_phase <= pk;
            out_last  <= (pk == K_LAST);
        end
    end

endmodule

// File: tb/tb_interpolator_nx.sv
// Scoreboard bench for interpolator_nx: a spec-level model predicts outputs, a monitor checks them.
module tb_interpolator_nx;
    import interpolator_pkg::*;

    localparam int DATA_W = 8;
    localparam int RATIO  = 10;
    localparam int COEF_W = 8;
    localparam int K_W    = $clog2(RATIO);
    localparam int EW     = 1 + K_W + DATA_W;

    logic              clk, reset_n;
    logic              in_valid, in_ready, out_valid, out_ready, out_last;
    logic [DATA_W-1:0] in_data, out_data;
    logic [K_W-1:0]    out_phase;
    state_t            fsm_state;

    logic        b_reset_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0]  b_in_data, b_out_data;
    logic [0:0]  b_out_phase;
    state_t      b_fsm_state;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    interpolator_nx #(.DATA_W(DATA_W), .RATIO(RATIO), .COEF_W(COEF_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_phase(out_phase), .out_last(out_last),
        .fsm_state(fsm_state)
    );

    interpolator_nx #(.DATA_W(8), .RATIO(2), .COEF_W(4)) dut2 (
        .clk(clk), .reset_n(b_reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_phase(b_out_phase), .out_last(b_out_last),
        .fsm_state(b_fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model
    function automatic int sval(input logic [DATA_W-1:0] x);
`ifdef INTERPOLATOR_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [EW-1:0] ref_out(input int a, input int b, input int k);
        int one, c1, y;
        one = 1 << COEF_W;
        c1  = $rtoi($floor(real'(k) * real'(one) / real'(RATIO) + 0.5));
        y   = (a * (one - c1) + b * c1 + one / 2) >>> COEF_W;
        return {(k == RATIO - 1), K_W'(k), DATA_W'(y)};
    endfunction

    bit m_primed = 0;
    int m_prev   = 0;
    int lat_cyc  = 0;

    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            if (m_primed) begin
                for (int k = 0; k < RATIO; k++) exp_q.push_back(ref_out(m_prev, sval(in_data), k));
                lat_cyc = cyc;
            end
            m_primed = 1;
            m_prev   = sval(in_data);
        end
    end

    // monitor
    bit            lat_chk = 0, lat_done = 0, gap_chk = 0, seen_any = 0, stalled_prev = 0;
    logic [EW-1:0] held;

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 0;
        end else begin
            if (stalled_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_last, out_phase, out_data}), 32'(held));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                stalled_prev = 1;
                held = {out_last, out_phase, out_data};
            end else begin
                stalled_prev = 0;
            end
            if (gap_chk && seen_any && exp_q.size() > 0) check("no_bubble", 32'(out_valid), 32'd1);
            if (out_valid) seen_any = 1;
            if (lat_chk && out_valid && !lat_done) begin
                check("latency", 32'(cyc - lat_cyc), 32'd4);
                lat_done = 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
                else check("out", 32'({out_last, out_phase, out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // out_ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = random
    int rdy_mode = 0, rdy_phase = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase++;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // driver tasks (entered and left at posedge + 1)
    task automatic send(input logic [DATA_W-1:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 2000);
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(3);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        exp_q.delete();
        m_primed = 0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bd[4];
    logic       bp[4], bl[4];
    int         bn;

    initial begin
        reset_n = 1'b0; b_reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_phase", 32'(out_phase), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(PRIME));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1; b_reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_edge", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ramp 0 -> 100, first output latency
        lat_chk = 1;
        send(8'd0); send(8'd100); idle(1);
        wait_drain();
        lat_chk = 0;

        // constant input held back-to-back
        do_reset();
        gap_chk = 1; seen_any = 0;
        send(8'd200); send(8'd200); send(8'd200); idle(1);
        wait_drain();
        gap_chk = 0;

        // ramp under out_ready 1,0,0,1
        do_reset();
        rdy_mode = 1; rdy_phase = 0;
        send(8'd0); send(8'd100); idle(1);
        wait_drain();
        rdy_mode = 0;

        // full-scale midpoint
        do_reset();
`ifdef INTERPOLATOR_SIGNED_EN
        send(8'h80); send(8'h7f); idle(1);
`else
        send(8'd255); send(8'd0); idle(1);
`endif
        wait_drain();

        // reset during phase 4
        do_reset();
        send(8'd10); send(8'd90); idle(1);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(out_valid && out_phase == 4) && n < 100);
            check("saw_phase4", 32'(out_phase), 32'd4);
        end
        #2 reset_n = 1'b0;
        exp_q.delete();
        m_primed = 0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_state", 32'(fsm_state), 32'(PRIME));
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd50); idle(15);
        check("prime_no_out", 32'(out_valid), 32'd0);
        send(8'd50); idle(1);
        wait_drain();

        // randomized traffic with random backpressure
        do_reset();
        rdy_mode = 2;
        repeat (40) begin
            send(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 12));
        end
        idle(1);
        wait_drain();
        rdy_mode = 0;

        // RATIO=2, COEF_W=4 instance: 0 then 15
        bn = 0;
        b_in_valid = 1'b1; b_in_data = 8'd0;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!b_in_ready && n < 50);
            @(posedge clk); #1;
            b_in_data = 8'd15;
            n = 0;
            do begin @(negedge clk); n++; end while (!b_in_ready && n < 50);
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (b_out_valid && bn < 4) begin
                    bd[bn] = b_out_data; bp[bn] = b_out_phase[0]; bl[bn] = b_out_last;
                    bn++;
                end
            end
        end
        check("r2_count", 32'(bn), 32'd2);
        check("r2_y0", 32'(bd[0]), 32'd0);
        check("r2_y1", 32'(bd[1]), 32'd8);
        check("r2_phase1", 32'(bp[1]), 32'd1);
        check("r2_last0", 32'(bl[0]), 32'd0);
        check("r2_last1", 32'(bl[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
